// File: rtl/sp_ram_master.sv
// sync_fifo: generic show-ahead FIFO for the response path.
// Latency: a push is visible on out_vld/out_dat the cycle after it is written.
// Backpressure: out_rdy pops; when full, a push is taken only together with a pop.
//
// Ports: clk_i/rst_n_i (sync active-low), in_vld/in_dat (push side),
//        out_vld/out_rdy/out_dat (show-ahead pop side).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             push;
    logic             pop;

    assign full    = (count_q == FULL_CNT);
    assign out_vld = (count_q != '0);
    assign pop     = out_vld && out_rdy;
    // A pop in the same cycle frees the slot being written, so push while full is legal.
    assign push    = in_vld && (!full || pop);
    // Empty FIFO presents zero rather than stale storage.
    assign out_dat = out_vld ? mem_q[rptr_q] : '0;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= in_dat;
    end
endmodule

// sp_ram_master: arbitrates write/read request channels onto one single-port RAM port.
// Latency: read handshake in cycle 0 -> response valid in cycle 3 (RAM latency 1) or 4 (latency 2).
// Backpressure: reads are only granted while fewer than RESP_DEPTH responses are owed.
//
// Ports: clk_i/rst_n_i (sync active-low); wr_* write request channel (valid/ready);
//        rd_* read request channel (valid/ready); rd_data_* response channel (valid/ready);
//        ram_* registered command to the RAM and ram_data_i read data back from it.
module sp_ram_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter     IS_OUT_LATENCY = "false",
    parameter int RESP_DEPTH     = 4,
    localparam int BYTE_VALID_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]       wr_addr_i,
    input  logic [DATA_WIDTH-1:0]       wr_data_i,
    input  logic [BYTE_VALID_WIDTH-1:0] wr_byte_valid_i,
    input  logic                        rd_valid_i,
    output logic                        rd_ready_o,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
    output logic                        rd_data_valid_o,
    input  logic                        rd_data_ready_i,
    output logic [DATA_WIDTH-1:0]       rd_data_o,
    output logic                        ram_wr_en_o,
    output logic [DATA_WIDTH-1:0]       ram_data_o,
    output logic [BYTE_VALID_WIDTH-1:0] ram_byte_valid_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_o,
    input  logic [DATA_WIDTH-1:0]       ram_data_i
);
    localparam int LAT = (IS_OUT_LATENCY == "true") ? 2 : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RESP_DEPTH);

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic [DATA_WIDTH-1:0]       data;
        logic [BYTE_VALID_WIDTH-1:0] be;
    } wr_req_t;

    typedef struct packed {
        logic                        wr_en;
        logic [ADDR_WIDTH-1:0]       addr;
        logic [DATA_WIDTH-1:0]       data;
        logic [BYTE_VALID_WIDTH-1:0] be;
    } ram_cmd_t;

    grant_e        last_q;
    grant_e        last_d;
    logic          wr_gnt;
    logic          rd_gnt;
    logic          rd_credit;
    logic [CW-1:0] cnt_q;
    logic          resp_pop;
    wr_req_t       wr_req;
    ram_cmd_t      ram_q;
    logic          rd_issue_q;
    logic [LAT-1:0] tag_q;

    assign wr_req = '{addr: wr_addr_i, data: wr_data_i, be: wr_byte_valid_i};

    // cnt_q counts reads accepted but not yet popped, so it also bounds FIFO occupancy.
    assign rd_credit = (cnt_q < CNT_MAX);
    assign resp_pop  = rd_data_valid_o && rd_data_ready_i;

    // Round-robin arbiter; the grants double as readies, so they are only raised with a valid.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        last_d = last_q;
        if (wr_valid_i && rd_valid_i) begin
            // A read that loses only for lack of credit yields the slot to the write.
            if (last_q == GNT_RD || !rd_credit) wr_gnt = 1'b1;
            else                                rd_gnt = 1'b1;
        end else if (wr_valid_i) begin
            wr_gnt = 1'b1;
        end else if (rd_valid_i && rd_credit) begin
            rd_gnt = 1'b1;
        end
        if (wr_gnt) last_d = GNT_WR;
        if (rd_gnt) last_d = GNT_RD;
    end

    assign wr_ready_o = wr_gnt;
    assign rd_ready_o = rd_gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) last_q <= GNT_RD;
        else          last_q <= last_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            case ({rd_gnt, resp_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Issue stage: the granted request becomes the RAM command for the next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ram_q <= '0;
        end else if (wr_gnt) begin
            ram_q.wr_en <= 1'b1;
            ram_q.addr  <= wr_req.addr;
            ram_q.data  <= wr_req.data;
            ram_q.be    <= wr_req.be;
        end else if (rd_gnt) begin
            ram_q.wr_en <= 1'b0;
            ram_q.addr  <= rd_addr_i;
            ram_q.be    <= '0;
        end else begin
            // Idle: address held to avoid needless toggling on the RAM pins.
            ram_q.wr_en <= 1'b0;
            ram_q.be    <= '0;
        end
    end

    assign ram_wr_en_o      = ram_q.wr_en;
    assign ram_addr_o       = ram_q.addr;
    assign ram_data_o       = ram_q.data;
    assign ram_byte_valid_o = ram_q.be;

    // rd_issue_q marks the cycle the RAM sees a read; the tag then rides LAT stages so
    // that it leaves exactly when the RAM's output carries that read's data.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_issue_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            rd_issue_q <= rd_gnt;
            tag_q[0]   <= rd_issue_q;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Credit accounting guarantees a free slot for every tagged push.
    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .in_vld  (tag_q[LAT-1]),
        .in_dat  (ram_data_i),
        .out_vld (rd_data_valid_o),
        .out_rdy (rd_data_ready_i),
        .out_dat (rd_data_o)
    );
endmodule

// File: tb/tb_sp_ram_master.sv
module tb_sp_ram_master;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_dvld, rd_drdy, ram_we;
    logic [AW-1:0] wr_addr, rd_addr, ram_addr;
    logic [DW-1:0] wr_data, rd_data, ram_wdat, ram_rdat;
    logic [BW-1:0] wr_be, ram_be;

    logic          wr_valid1, wr_ready1, rd_valid1, rd_ready1, rd_dvld1, rd_drdy1, ram_we1;
    logic [AW-1:0] wr_addr1, rd_addr1, ram_addr1;
    logic [DW-1:0] wr_data1, rd_data1, ram_wdat1, ram_rdat1;
    logic [BW-1:0] wr_be1, ram_be1;

    sp_ram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_OUT_LATENCY("false"), .RESP_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_byte_valid_i(wr_be), .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
        .rd_data_valid_o(rd_dvld), .rd_data_ready_i(rd_drdy), .rd_data_o(rd_data),
        .ram_wr_en_o(ram_we), .ram_data_o(ram_wdat), .ram_byte_valid_o(ram_be),
        .ram_addr_o(ram_addr), .ram_data_i(ram_rdat));

    sp_ram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_OUT_LATENCY("true"), .RESP_DEPTH(DEPTH)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_valid_i(wr_valid1), .wr_ready_o(wr_ready1), .wr_addr_i(wr_addr1), .wr_data_i(wr_data1),
        .wr_byte_valid_i(wr_be1), .rd_valid_i(rd_valid1), .rd_ready_o(rd_ready1), .rd_addr_i(rd_addr1),
        .rd_data_valid_o(rd_dvld1), .rd_data_ready_i(rd_drdy1), .rd_data_o(rd_data1),
        .ram_wr_en_o(ram_we1), .ram_data_o(ram_wdat1), .ram_byte_valid_o(ram_be1),
        .ram_addr_o(ram_addr1), .ram_data_i(ram_rdat1));

    // Behavioural single-port RAMs: latency 1 for dut, latency 2 for dut1.
    logic [DW-1:0] mem0 [256] = '{default: '0};
    logic [DW-1:0] mem1 [256] = '{default: '0};
    logic [DW-1:0] q0, q1a, q1b, w0, w1;
    always @(posedge clk) begin
        if (ram_we) begin
            w0 = mem0[ram_addr];
            for (int i = 0; i < BW; i++) if (ram_be[i]) w0[8*i +: 8] = ram_wdat[8*i +: 8];
            mem0[ram_addr] <= w0;
        end
        q0 <= mem0[ram_addr];
    end
    always @(posedge clk) begin
        if (ram_we1) begin
            w1 = mem1[ram_addr1];
            for (int i = 0; i < BW; i++) if (ram_be1[i]) w1[8*i +: 8] = ram_wdat1[8*i +: 8];
            mem1[ram_addr1] <= w1;
        end
        q1a <= mem1[ram_addr1];
        q1b <= q1a;
    end
    assign ram_rdat  = q0;
    assign ram_rdat1 = q1b;

    // Reference model: memory image, queue of owed responses, last granted channel.
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    logic [DW-1:0] exp_q [$];
    logic          m_last_rd;

    int checks = 0;
    int errors = 0;

    logic          obs_w, obs_r, exp_w, exp_r, seen_vld, resp, resp_unexp;
    logic [DW-1:0] resp_dat, exp_dat;

    // One cycle: drive, sample mid-cycle, update the model from the observed handshakes.
    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [BW-1:0] wb, input logic rv, input logic [AW-1:0] ra,
                        input logic dr);
        logic credit;
        @(negedge clk);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = wb;
        rd_valid = rv; rd_addr = ra; rd_drdy = dr;
        #1;
        credit = (exp_q.size() < DEPTH);
        exp_w = 1'b0; exp_r = 1'b0;
        if (wv && rv) begin
            if (m_last_rd || !credit) exp_w = 1'b1; else exp_r = 1'b1;
        end else if (wv) exp_w = 1'b1;
        else if (rv && credit) exp_r = 1'b1;
        obs_w = wr_ready; obs_r = rd_ready; seen_vld = rd_dvld;
        resp = rd_dvld && dr; resp_dat = rd_data; resp_unexp = 1'b0; exp_dat = '0;
        if (resp) begin
            if (exp_q.size() == 0) resp_unexp = 1'b1;
            else exp_dat = exp_q.pop_front();
        end
        if (wv && obs_w) begin
            for (int i = 0; i < BW; i++) if (wb[i]) ref_mem[wa][8*i +: 8] = wd[8*i +: 8];
            m_last_rd = 1'b0;
        end
        if (rv && obs_r) begin
            exp_q.push_back(ref_mem[ra]);
            m_last_rd = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", ram_we); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
        checks++; if (ram_wdat !== '0) begin errors++; $display("FAIL rst_ram_data: got %h want 0", ram_wdat); end
        checks++; if (ram_be !== '0) begin errors++; $display("FAIL rst_byte_valid: got %h want 0", ram_be); end
        checks++; if (rd_dvld !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", rd_dvld); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
        rst_n = 1'b1;
        exp_q.delete(); m_last_rd = 1'b1;
        // First contended cycle after reset must go to the write.
        step(1'b1, 8'h01, 32'h12345678, 4'hF, 1'b1, 8'h01, 1'b1);
        checks++; if (obs_w !== 1'b1 || obs_r !== 1'b0)
            begin errors++; $display("FAIL rst_first_grant: got w=%b r=%b want w=1 r=0", obs_w, obs_r); end
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_byte_mask();
        step(1'b1, 8'h10, 32'hAABBCCDD, 4'b0101, 1'b0, '0, 1'b1);
        checks++; if (obs_w !== 1'b1) begin errors++; $display("FAIL bm_wr_accept: got %b want 1", obs_w); end
        step(1'b0, '0, '0, '0, 1'b1, 8'h10, 1'b1);
        checks++; if (obs_r !== 1'b1) begin errors++; $display("FAIL bm_rd_accept: got %b want 1", obs_r); end
        checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_be !== 4'b0101 || ram_wdat !== 32'hAABBCCDD)
            begin errors++; $display("FAIL bm_issue_write: got we=%b a=%h be=%b d=%h", ram_we, ram_addr, ram_be, ram_wdat); end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            if (k == 1) begin
                checks++; if (ram_we !== 1'b0 || ram_addr !== 8'h10 || ram_be !== 4'b0000)
                    begin errors++; $display("FAIL bm_issue_read: got we=%b a=%h be=%b", ram_we, ram_addr, ram_be); end
            end
            checks++; if (seen_vld !== (k == 3))
                begin errors++; $display("FAIL bm_timing cycle %0d: got valid=%b want %b", k, seen_vld, (k == 3)); end
            if (k == 3) begin
                checks++; if (resp_dat !== 32'h00BB00DD)
                    begin errors++; $display("FAIL bm_data: got %h want 00bb00dd", resp_dat); end
            end
        end
    endtask

    task automatic test_stream();
        int nacc = 0, nresp = 0, first = -1, last = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, AW'(i), $urandom, 4'hF, 1'b0, '0, 1'b1);
            if (obs_w) nacc++;
        end
        checks++; if (nacc != 16) begin errors++; $display("FAIL stream_prefill: got %0d want 16", nacc); end
        nacc = 0;
        for (int t = 0; t < 28; t++) begin
            step(1'b0, '0, '0, '0, (t < 16), AW'(t), 1'b1);
            if (t < 16 && obs_r) nacc++;
            if (resp) begin
                nresp++;
                if (first < 0) first = t;
                last = t;
                checks++; if (resp_unexp || resp_dat !== exp_dat)
                    begin errors++; $display("FAIL stream_data: got %h want %h", resp_dat, exp_dat); end
            end
        end
        checks++; if (nacc != 16) begin errors++; $display("FAIL stream_rd_ready: got %0d accepts want 16", nacc); end
        checks++; if (nresp != 16 || last - first != 15)
            begin errors++; $display("FAIL stream_throughput: got %0d resps over %0d cycles want 16 over 16", nresp, last - first + 1); end
    endtask

    task automatic test_backpressure();
        int nacc = 0, nresp = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
            if (obs_r) nacc++;
            checks++; if (obs_r !== exp_r) begin errors++; $display("FAIL bp_ready cycle %0d: got %b want %b", i, obs_r, exp_r); end
        end
        checks++; if (nacc != DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", nacc, DEPTH); end
        for (int t = 0; t < 10; t++) begin
            step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            if (resp) begin
                nresp++;
                checks++; if (resp_unexp || resp_dat !== exp_dat)
                    begin errors++; $display("FAIL bp_data: got %h want %h", resp_dat, exp_dat); end
            end
        end
        checks++; if (nresp != DEPTH) begin errors++; $display("FAIL bp_drain: got %0d want %0d", nresp, DEPTH); end
        step(1'b0, '0, '0, '0, 1'b1, 8'h05, 1'b1);
        checks++; if (obs_r !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", obs_r); end
        for (int t = 0; t < 5; t++) begin
            step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            if (resp) begin
                checks++; if (resp_unexp || resp_dat !== exp_dat)
                    begin errors++; $display("FAIL bp_resume_data: got %h want %h", resp_dat, exp_dat); end
            end
        end
    endtask

    task automatic test_contention();
        int nw = 0, nresp = 0;
        for (int t = 0; t < 12; t++) begin
            step((t < 6), 8'h20, 32'h1000_0000 + nw, 4'hF, (t < 6), 8'h20, 1'b1);
            if (t < 6) begin
                checks++; if (obs_w !== (t % 2 == 0) || obs_r !== (t % 2 == 1))
                    begin errors++; $display("FAIL cont_grant cycle %0d: got w=%b r=%b", t, obs_w, obs_r); end
                if (obs_w) nw++;
            end
            if (resp) begin
                nresp++;
                checks++; if (resp_unexp || resp_dat !== exp_dat)
                    begin errors++; $display("FAIL cont_data: got %h want %h", resp_dat, exp_dat); end
            end
        end
        checks++; if (nresp != 3) begin errors++; $display("FAIL cont_resps: got %0d want 3", nresp); end
    endtask

    task automatic test_reset_mid();
        int nacc = 0, nresp = 0, nvld = 0;
        step(1'b0, '0, '0, '0, 1'b1, 8'h01, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 8'h02, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); m_last_rd = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            if (seen_vld) nvld++;
        end
        checks++; if (nvld != 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d responses want 0", nvld); end
        for (int t = 0; t < 6; t++) begin
            step(1'b0, '0, '0, '0, 1'b1, AW'(t + 3), 1'b0);
            if (obs_r) nacc++;
        end
        checks++; if (nacc != DEPTH) begin errors++; $display("FAIL rstmid_credit: got %0d want %0d", nacc, DEPTH); end
        for (int t = 0; t < 10; t++) begin
            step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            if (resp) begin
                nresp++;
                checks++; if (resp_unexp || resp_dat !== exp_dat)
                    begin errors++; $display("FAIL rstmid_data: got %h want %h", resp_dat, exp_dat); end
            end
        end
        checks++; if (nresp != DEPTH) begin errors++; $display("FAIL rstmid_resps: got %0d want %0d", nresp, DEPTH); end
    endtask

    task automatic test_random();
        int bad_rdy = 0, bad_dat = 0;
        for (int t = 0; t < 420; t++) begin
            if (t < 400)
                step(1'($urandom), AW'($urandom_range(0, 15)), $urandom, BW'($urandom),
                     1'($urandom), AW'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            else
                step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            if (obs_w !== exp_w || obs_r !== exp_r) bad_rdy++;
            if (resp && (resp_unexp || resp_dat !== exp_dat)) bad_dat++;
        end
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL rand_grants: got %0d wrong cycles want 0", bad_rdy); end
        checks++; if (bad_dat != 0) begin errors++; $display("FAIL rand_data: got %0d wrong responses want 0", bad_dat); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d owed want 0", exp_q.size()); end
    endtask

    task automatic test_out_latency();
        int first = -1;
        logic [DW-1:0] got = '0;
        @(negedge clk);
        wr_valid1 = 1'b1; wr_addr1 = 8'h10; wr_data1 = 32'hAABBCCDD; wr_be1 = 4'b0101; rd_drdy1 = 1'b1;
        #1;
        checks++; if (wr_ready1 !== 1'b1) begin errors++; $display("FAIL lat2_wr_accept: got %b want 1", wr_ready1); end
        @(negedge clk);
        wr_valid1 = 1'b0; rd_valid1 = 1'b1; rd_addr1 = 8'h10;
        #1;
        checks++; if (rd_ready1 !== 1'b1) begin errors++; $display("FAIL lat2_rd_accept: got %b want 1", rd_ready1); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rd_valid1 = 1'b0;
            #1;
            if (rd_dvld1 && first < 0) begin first = k; got = rd_data1; end
        end
        checks++; if (first != 4) begin errors++; $display("FAIL lat2_timing: got cycle %0d want 4", first); end
        checks++; if (got !== 32'h00BB00DD) begin errors++; $display("FAIL lat2_data: got %h want 00bb00dd", got); end
    endtask

    initial begin
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_valid = 0; rd_addr = '0; rd_drdy = 0;
        wr_valid1 = 0; wr_addr1 = '0; wr_data1 = '0; wr_be1 = '0; rd_valid1 = 0; rd_addr1 = '0; rd_drdy1 = 0;
        m_last_rd = 1'b1;
        test_reset();
        test_byte_mask();
        test_out_latency();
        test_stream();
        test_backpressure();
        test_contention();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sp_ram_master.md
Name: sp_ram_master

Overview:
Initiator-side front end for the team's single-port byte-enabled RAM. It accepts independent write and read request channels (valid/ready), arbitrates them onto the RAM's single port, and tracks the RAM's read latency. Read data is returned through a credit-limited response FIFO with downstream backpressure. It sits between bus or stream logic and a single_port_ram instance built with the same DATA_WIDTH, ADDR_WIDTH and IS_OUT_LATENCY.

Parameters:
DATA_WIDTH, 8, data width in bits; multiple of 8.
ADDR_WIDTH, 8, RAM address width.
IS_OUT_LATENCY, "false", must match the RAM setting; "false" gives RAM read latency 1 and "true" gives latency 2.
RESP_DEPTH, 4, response FIFO depth; power of 2, minimum 2; also the maximum number of outstanding reads.
BYTE_VALID_WIDTH (localparam), DATA_WIDTH/8.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n_i  in  1  synchronous reset, active-low
wr_valid_i  in  1  write request valid
wr_ready_o  out  1  write request accepted when high together with wr_valid_i
wr_addr_i  in  ADDR_WIDTH  write address
wr_data_i  in  DATA_WIDTH  write data
wr_byte_valid_i  in  BYTE_VALID_WIDTH  per-byte write enable
rd_valid_i  in  1  read request valid
rd_ready_o  out  1  read request accepted
rd_addr_i  in  ADDR_WIDTH  read address
rd_data_valid_o  out  1  response valid
rd_data_ready_i  in  1  response consumed when high together with rd_data_valid_o
rd_data_o  out  DATA_WIDTH  response data
ram_wr_en_o  out  1  to RAM wr_en_i
ram_data_o  out  DATA_WIDTH  to RAM data_i
ram_byte_valid_o  out  BYTE_VALID_WIDTH  to RAM byte_valid_i
ram_addr_o  out  ADDR_WIDTH  to RAM addr_i
ram_data_i  in  DATA_WIDTH  from RAM data_o

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - ram_wr_en_o=0; ram_addr_o, ram_data_o, ram_byte_valid_o, rd_data_o all 0.
  - rd_data_valid_o=0; FIFO empty; outstanding counter 0; latency tag pipe cleared.
  - last_grant=READ, so the first contended cycle goes to write.
  - In-flight reads at reset are discarded and never returned.
- Arbitration (combinational, one grant per cycle):
  - Only write valid: grant write.
  - Only read valid: grant read, if credit is available.
  - Both valid: grant the channel opposite to last_grant (round-robin). If read is chosen but has no credit, grant write instead.
  - last_grant updates only on an accepted handshake.
  - wr_ready_o and rd_ready_o may depend on the valids, and are never both high.
- Credit:
  - Counter cnt, range 0..RESP_DEPTH.
  - Increments on a read handshake and decrements on a response pop; simultaneous increment and decrement leaves it unchanged.
  - A read can be granted only when cnt<RESP_DEPTH, which guarantees the FIFO never overflows.
- Issue stage (registered): on the edge ending handshake cycle 0, the RAM outputs load for cycle 1.
  - Write: ram_wr_en_o=1, ram_addr_o, ram_data_o and ram_byte_valid_o from the request.
  - Read: ram_wr_en_o=0, ram_addr_o=rd_addr_i, ram_byte_valid_o=0.
  - Idle: ram_wr_en_o=0, ram_byte_valid_o=0, ram_addr_o holds its value.
- Latency tracking:
  - A tag shift register of length LAT (1 or 2) is set on read issue.
  - When the tag exits, ram_data_i is pushed into the FIFO.
  - RAM output during write or idle cycles is ignored; it is not tagged.
- Timing:
  - Read accepted in cycle 0 gives rd_data_valid_o=1 in cycle 3 (IS_OUT_LATENCY="false") or cycle 4 ("true"), with an empty FIFO.
  - Full throughput: one request per cycle, one response per cycle.
- Ordering:
  - Responses are returned in request order.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- FIFO:
  - Show-ahead: rd_data_o is valid whenever rd_data_valid_o=1 and holds stable until popped.
  - Push and pop in the same cycle are legal, including when the FIFO is full or empty-with-push.
  - Pointers wrap modulo RESP_DEPTH.

Test Plan:
- Byte-masked write then read: write addr 0x10 data 0xAABBCCDD with byte_valid 4'b0101 over initial value 0x00000000, then read 0x10 → rd_data_o=0x00BB00DD, 3 cycles after the read handshake.
- Streaming reads: 16 back-to-back reads of addresses 0..15 with rd_data_ready_i=1 → rd_ready_o stays high, 16 in-order responses on consecutive cycles.
- Backpressure: rd_data_ready_i=0 with continuous reads → exactly RESP_DEPTH (4) reads accepted, then rd_ready_o=0. Release ready → 4 responses delivered in order, then accepts resume.
- Contention: wr_valid_i and rd_valid_i both high for 6 cycles → grants alternate W,R,W,R,W,R, and each read returns data including the preceding write.
- Reset mid-operation: rst_n_i=0 for 1 cycle with 2 reads in flight → no response ever appears, cnt=0, next read returns normally.
- IS_OUT_LATENCY="true": repeat the first scenario → response appears in cycle 4.
